multicycle_datapath: RTL and testbench

- 16-bit multicycle RISC datapath: PC, 256x16 unified instruction/data memory, instruction register, 8x16 register file, add/sub ALU with NZC status word, and inter-step buffer registers.
- Driven cycle-by-cycle by an external controller through individual control strobes; exposes opcode fields and flags back to it.
- A bench port allows direct memory loading.

---
 rtl/multicycle_datapath.sv | 178 +++++++++++++++++
 tb/tb_multicycle_datapath.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// 16-bit multicycle RISC datapath: PC, unified 256x16 memory, IR, 8x16 register file,
// add/sub ALU with NZC status word and step buffer registers, sequenced by an external controller.
module multicycle_datapath (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Buff_PC,
    input  logic        Buff_MEMIns,
    input  logic        MEMresource,
    input  logic        WE_MEM,
    input  logic        ALUorNot,
    input  logic        LIorMOV,
    input  logic        WBresource,
    input  logic        RBresource,
    input  logic        oprandB,
    input  logic        LI,
    input  logic        PCplus1orWB,
    input  logic        WE_RF,
    input  logic        Branch,
    input  logic [1:0]  Jump,
    input  logic        ALUop,
    input  logic        Flag,
    input  logic        Buff_PSW,
    input  logic        TBorNot,
    input  logic        Tb_MEMWE,
    input  logic [7:0]  Tb_MEMAddr,
    input  logic [15:0] Tb_MEMData,
    output logic [15:0] OutR,
    output logic [2:0]  PSW_NZC,
    output logic [4:0]  opcode,
    output logic [1:0]  ALUopcode,
    output logic [15:0] OutM,
    output logic [15:0] OutPC,
    output logic [15:0] OutNextPC
);
    logic [15:0] mem [256];

    logic [15:0] pc_q, pc_d, ir_q, ir_d;
    logic [15:0] a_q, a_d, b_q, b_d, l_q, l_d;
    logic [15:0] s_q, s_d, r_q, r_d, w_q, w_d, mdr_q, mdr_d;
    logic [2:0]  psw_q, psw_d;
    logic        s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];

    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] port_a, port_b;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [16:0] alu_sum;
    logic [15:0] pc_inc, next_pc, rf_wdata;
    logic        br_taken;

    // Memory port: the bench takes over address, data and write enable when TBorNot is set
    always_comb begin
        mem_addr  = MEMresource ? r_q[7:0] : pc_q[7:0];
        mem_we    = WE_MEM;
        mem_wdata = s_q;
        if (TBorNot) begin
            mem_addr  = Tb_MEMAddr;
            mem_we    = Tb_MEMWE;
            mem_wdata = Tb_MEMData;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_comb begin
        port_a  = rf_q[ir_q[7:5]];
        port_b  = rf_q[RBresource ? ir_q[10:8] : ir_q[4:2]];

        // Subtract is A + ~B + 1; with Flag the stored carry replaces the constant carry-in
        alu_b   = ALUop ? ~b_q : b_q;
        alu_cin = ALUop ? (Flag ? psw_q[0] : 1'b1) : (Flag & psw_q[0]);
        alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {16'h0000, alu_cin};

        case (ir_q[10:8])
            3'b000:  br_taken = psw_q[1];
            3'b001:  br_taken = ~psw_q[1];
            3'b010:  br_taken = psw_q[0];
            3'b011:  br_taken = ~psw_q[0];
            3'b100:  br_taken = psw_q[2];
            3'b101:  br_taken = ~psw_q[2];
            3'b110:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase

        pc_inc = pc_q + 16'd1;
        if (Jump == 2'b01)
            next_pc = pc_inc + {{5{ir_q[10]}}, ir_q[10:0]};
        else if (Jump == 2'b10)
            next_pc = s_q;
        else if (Branch && br_taken)
            next_pc = pc_inc + {{8{ir_q[7]}}, ir_q[7:0]};
        else
            next_pc = pc_inc;

        rf_wdata = PCplus1orWB ? (WBresource ? mdr_q : w_q) : pc_inc;
    end

    always_comb begin
        pc_d  = Buff_PC ? next_pc : pc_q;
        ir_d  = Buff_MEMIns ? OutM : ir_q;
        s2_d  = Buff_MEMIns;
        s3_d  = s2_q;
        s4_d  = s3_q;
        a_d   = a_q;
        b_d   = b_q;
        l_d   = l_q;
        s_d   = s_q;
        r_d   = r_q;
        psw_d = psw_q;
        w_d   = w_q;
        mdr_d = mdr_q;
        rf_d  = rf_q;
        if (s2_q) begin
            a_d = port_a;
            b_d = oprandB ? {11'h000, ir_q[4:0]} : port_b;
            l_d = LI ? {ir_q[7:0], port_b[7:0]} : {8'h00, ir_q[7:0]};
        end
        if (s3_q) begin
            s_d = port_b;
            r_d = alu_sum[15:0];
            if (Buff_PSW) psw_d = {alu_sum[15], alu_sum[15:0] == 16'h0000, alu_sum[16]};
        end
        if (s4_q) begin
            w_d   = ALUorNot ? (LIorMOV ? a_q : l_q) : r_q;
            mdr_d = OutM;
        end
        if (WE_RF) rf_d[ir_q[10:8]] = rf_wdata;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            psw_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            l_q   <= '0;
            s_q   <= '0;
            r_q   <= '0;
            w_q   <= '0;
            mdr_q <= '0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            s4_q  <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            psw_q <= psw_d;
            a_q   <= a_d;
            b_q   <= b_d;
            l_q   <= l_d;
            s_q   <= s_d;
            r_q   <= r_d;
            w_q   <= w_d;
            mdr_q <= mdr_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            s4_q  <= s4_d;
            rf_q  <= rf_d;
        end
    end

    assign OutR      = port_a;
    assign PSW_NZC   = psw_q;
    assign opcode    = ir_q[15:11];
    assign ALUopcode = ir_q[1:0];
    assign OutM      = mem[mem_addr];
    assign OutPC     = pc_q;
    assign OutNextPC = next_pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: plays the controller for a short program and scores
// register, PC, PSW and memory results against expectations queued per instruction.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Buff_PC = 0, Buff_MEMIns = 0, MEMresource = 0, WE_MEM = 0;
    logic        ALUorNot = 0, LIorMOV = 0, WBresource = 0, RBresource = 0;
    logic        oprandB = 0, LI = 0, PCplus1orWB = 0, WE_RF = 0, Branch = 0;
    logic [1:0]  Jump = 2'b00;
    logic        ALUop = 0, Flag = 0, Buff_PSW = 0;
    logic        TBorNot = 0, Tb_MEMWE = 0;
    logic [7:0]  Tb_MEMAddr = '0;
    logic [15:0] Tb_MEMData = '0;
    logic [15:0] OutR, OutM, OutPC, OutNextPC;
    logic [2:0]  PSW_NZC;
    logic [4:0]  opcode;
    logic [1:0]  ALUopcode;

    multicycle_datapath dut (
        .clk(clk), .Rst(Rst), .Buff_PC(Buff_PC), .Buff_MEMIns(Buff_MEMIns),
        .MEMresource(MEMresource), .WE_MEM(WE_MEM), .ALUorNot(ALUorNot), .LIorMOV(LIorMOV),
        .WBresource(WBresource), .RBresource(RBresource), .oprandB(oprandB), .LI(LI),
        .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF), .Branch(Branch), .Jump(Jump),
        .ALUop(ALUop), .Flag(Flag), .Buff_PSW(Buff_PSW), .TBorNot(TBorNot),
        .Tb_MEMWE(Tb_MEMWE), .Tb_MEMAddr(Tb_MEMAddr), .Tb_MEMData(Tb_MEMData),
        .OutR(OutR), .PSW_NZC(PSW_NZC), .opcode(opcode), .ALUopcode(ALUopcode),
        .OutM(OutM), .OutPC(OutPC), .OutNextPC(OutNextPC)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_res, we_mem, alu_or_not, li_or_mov, wb_res, rb_res;
        logic       opr_b, li, pc1_or_wb, we_rf, branch;
        logic [1:0] jump;
        logic       aluop, flag, buff_psw;
    } ctrl_t;

    // Observation sources: 0..7 register file entry, 8 PC, 9 OutR, 10 PSW
    typedef struct {
        string       tag;
        int          src;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] model_pc;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input int src, input logic [15:0] val);
        sb.push_back('{tag, src, val});
    endtask

    task automatic sb_drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.src < 8)       obs = dut.rf_q[e.src];
            else if (e.src == 8) obs = OutPC;
            else if (e.src == 9) obs = OutR;
            else                 obs = {13'h0000, PSW_NZC};
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [15:0] enc_ri(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] enc_rrr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                            input logic [2:0] rb, input logic [1:0] fn);
        return {op, rd, ra, rb, fn};
    endfunction

    function automatic logic [15:0] enc_rri(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                            input logic [4:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic ctrl_t c_lli();
        ctrl_t c = '0;
        c.alu_or_not = 1'b1; c.pc1_or_wb = 1'b1; c.we_rf = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_lhi();
        ctrl_t c = c_lli();
        c.rb_res = 1'b1; c.li = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_mov();
        ctrl_t c = c_lli();
        c.li_or_mov = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_alu(input logic sub, input logic flg, input logic imm, input logic wr);
        ctrl_t c = '0;
        c.aluop = sub; c.flag = flg; c.opr_b = imm; c.buff_psw = 1'b1;
        c.pc1_or_wb = 1'b1; c.we_rf = wr;
        return c;
    endfunction

    function automatic ctrl_t c_str();
        ctrl_t c = '0;
        c.opr_b = 1'b1; c.rb_res = 1'b1; c.mem_res = 1'b1; c.we_mem = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_ldr();
        ctrl_t c = '0;
        c.opr_b = 1'b1; c.mem_res = 1'b1; c.wb_res = 1'b1; c.pc1_or_wb = 1'b1; c.we_rf = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_flow(input logic br, input logic [1:0] jmp);
        ctrl_t c = '0;
        c.branch = br; c.jump = jmp; c.rb_res = 1'b1;
        return c;
    endfunction

    task automatic mem_write(input logic [7:0] addr, input logic [15:0] data);
        TBorNot = 1'b1; Tb_MEMWE = 1'b1; Tb_MEMAddr = addr; Tb_MEMData = data;
        @(posedge clk); #1;
        Tb_MEMWE = 1'b0; TBorNot = 1'b0;
    endtask

    task automatic drive(input ctrl_t c, input int step);
        Buff_MEMIns = (step == 1);
        MEMresource = (step == 1) ? 1'b0 : c.mem_res;
        WE_MEM      = (step == 4) && c.we_mem;
        ALUorNot    = c.alu_or_not;
        LIorMOV     = c.li_or_mov;
        WBresource  = c.wb_res;
        RBresource  = c.rb_res;
        oprandB     = c.opr_b;
        LI          = c.li;
        PCplus1orWB = c.pc1_or_wb;
        WE_RF       = (step == 5) && c.we_rf;
        Buff_PC     = (step == 5);
        Branch      = c.branch;
        Jump        = c.jump;
        ALUop       = c.aluop;
        Flag        = c.flag;
        Buff_PSW    = (step == 3) && c.buff_psw;
    endtask

    task automatic run_steps(input ctrl_t c, input int nsteps);
        for (int st = 1; st <= nsteps; st++) begin
            drive(c, st);
            @(posedge clk); #1;
        end
        drive('0, 0);
    endtask

    // Runs one five-step instruction at model_pc, optionally placing its word in memory first
    task automatic exec(input logic [15:0] instr, input ctrl_t c, input bit preload, input logic [15:0] exp_pc);
        if (preload) mem_write(model_pc[7:0], instr);
        sb_push("pc", 8, exp_pc);
        run_steps(c, 5);
        sb_drain();
        model_pc = exp_pc;
    endtask

    localparam logic [4:0] OP_LLI = 5'd1, OP_LHI = 5'd2, OP_OUT = 5'd3, OP_MOV = 5'd4;
    localparam logic [4:0] OP_ALU = 5'd5, OP_STR = 5'd6, OP_LDR = 5'd7, OP_BR = 5'd8;
    localparam logic [4:0] OP_JMP = 5'd9, OP_JR = 5'd10, OP_JAL = 5'd11, OP_HLT = 5'd31;

    initial begin
        drive('0, 0);
        mem_write(8'd0, enc_ri(OP_LLI, 3'd1, 8'hF1));
        mem_write(8'd1, enc_ri(OP_LHI, 3'd1, 8'hF5));
        mem_write(8'd2, enc_ri(OP_LLI, 3'd2, 8'h77));
        mem_write(8'd3, enc_rri(OP_OUT, 3'd0, 3'd2, 5'd0));
        mem_write(8'd4, enc_rri(OP_MOV, 3'd2, 3'd1, 5'd0));
        mem_write(8'd5, enc_rri(OP_OUT, 3'd0, 3'd2, 5'd0));
        mem_write(8'd6, enc_ri(OP_HLT, 3'd0, 8'h00));
        Rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 Rst = 1'b0;
        model_pc = 16'h0000;

        check("reset_pc", OutPC, 16'h0000);
        check("reset_psw", {13'h0000, PSW_NZC}, 16'h0000);
        check("reset_outr", OutR, 16'h0000);
        check("reset_nextpc", OutNextPC, 16'h0001);
        check("preload_mem0", OutM, 16'h09F1);

        sb_push("lli_r1", 1, 16'h00F1);
        exec(16'h0000, c_lli(), 1'b0, 16'h0001);
        sb_push("lhi_r1", 1, 16'hF5F1);
        exec(16'h0000, c_lhi(), 1'b0, 16'h0002);
        sb_push("lli_r2", 2, 16'h0077);
        exec(16'h0000, c_lli(), 1'b0, 16'h0003);
        sb_push("out_r2_a", 9, 16'h0077);
        exec(16'h0000, '0, 1'b0, 16'h0004);
        sb_push("mov_r2", 2, 16'hF5F1);
        exec(16'h0000, c_mov(), 1'b0, 16'h0005);
        sb_push("out_r2_b", 9, 16'hF5F1);
        exec(16'h0000, '0, 1'b0, 16'h0006);

        sb_push("lli_r3", 3, 16'h00FF);
        exec(enc_ri(OP_LLI, 3'd3, 8'hFF), c_lli(), 1'b1, 16'h0007);
        sb_push("lhi_r3", 3, 16'h7FFF);
        exec(enc_ri(OP_LHI, 3'd3, 8'h7F), c_lhi(), 1'b1, 16'h0008);
        sb_push("lli_r4", 4, 16'h0001);
        exec(enc_ri(OP_LLI, 3'd4, 8'h01), c_lli(), 1'b1, 16'h0009);
        sb_push("add_ovf", 5, 16'h8000);
        sb_push("add_nzc", 10, 16'h0004);
        exec(enc_rrr(OP_ALU, 3'd5, 3'd3, 3'd4, 2'd0), c_alu(1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 16'h000A);
        sb_push("lli_r6", 6, 16'h0005);
        exec(enc_ri(OP_LLI, 3'd6, 8'h05), c_lli(), 1'b1, 16'h000B);
        sb_push("sub_zero", 6, 16'h0000);
        sb_push("sub_nzc", 10, 16'h0003);
        exec(enc_rri(OP_ALU, 3'd6, 3'd6, 5'd5), c_alu(1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 16'h000C);
        sb_push("adc_sum", 7, 16'h0003);
        sb_push("adc_nzc", 10, 16'h0000);
        exec(enc_rrr(OP_ALU, 3'd7, 3'd4, 3'd4, 2'd0), c_alu(1'b0, 1'b1, 1'b0, 1'b1), 1'b1, 16'h000D);

        sb_push("lli_r1_7c", 1, 16'h007C);
        exec(enc_ri(OP_LLI, 3'd1, 8'h7C), c_lli(), 1'b1, 16'h000E);
        exec(enc_rri(OP_STR, 3'd1, 3'd0, 5'd10), c_str(), 1'b1, 16'h000F);
        TBorNot = 1'b1; Tb_MEMAddr = 8'h0A;
        #1 check("str_mem0a", OutM, 16'h007C);
        TBorNot = 1'b0;
        sb_push("ldr_r2", 2, 16'h007C);
        exec(enc_rri(OP_LDR, 3'd2, 3'd0, 5'd10), c_ldr(), 1'b1, 16'h0010);

        sb_push("cmp_nzc", 10, 16'h0003);
        exec(enc_rrr(OP_ALU, 3'd0, 3'd4, 3'd4, 2'd1), c_alu(1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 16'h0011);
        exec(enc_ri(OP_BR, 3'b000, 8'hFE), c_flow(1'b1, 2'b00), 1'b1, 16'h0010);
        exec(enc_ri(OP_BR, 3'b111, 8'hFE), c_flow(1'b1, 2'b00), 1'b1, 16'h0011);
        exec(enc_ri(OP_BR, 3'b010, 8'h05), c_flow(1'b1, 2'b00), 1'b1, 16'h0017);
        exec({OP_JMP, 11'h7E0}, c_flow(1'b0, 2'b01), 1'b1, 16'hFFF8);
        exec(enc_ri(OP_JR, 3'd3, 8'h00), c_flow(1'b0, 2'b10), 1'b1, 16'h7FFF);
        begin
            ctrl_t cj = '0;
            cj.we_rf = 1'b1;
            sb_push("jal_link", 5, 16'h8000);
            exec(enc_ri(OP_JAL, 3'd5, 8'h00), cj, 1'b1, 16'h8000);
        end

        // Abort an instruction after three steps; the next one must start with a clean fetch
        run_steps(c_lhi(), 3);
        Rst = 1'b1;
        @(posedge clk); #1;
        Rst = 1'b0;
        check("rst_pc", OutPC, 16'h0000);
        check("rst_psw", {13'h0000, PSW_NZC}, 16'h0000);
        for (int i = 0; i < 8; i++) check($sformatf("rst_rf%0d", i), dut.rf_q[i], 16'h0000);
        model_pc = 16'h0000;
        sb_push("refetch_r1", 1, 16'h00F1);
        exec(16'h0000, c_lli(), 1'b0, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
